seq_stage_ctrl: RTL and testbench
=================================

// Module: seq_stage_ctrl
// PURPOSE
//  Sequencing FSM for the Y86-64 SEQ datapath. Steps each instruction through fetch, decode,
//  execute, memory, writeback and PC-update by strobing one stage enable per cycle.
//  Gates CC writes from the execute stage, runs the data-memory req/ack handshake, and owns the
//  processor status (AOK/HLT/ADR/INS). Sits above the fetch/decode/ALU/CC/memory blocks.
// PARAMETERS
//  CNT_W        32  width of retired-instruction counter
//  MEM_TIMEOUT  15  max MEM_WAIT cycles before ADR fault (1..255)
// PORTS
//  clk          in   1      clock, all state updates on rising edge
//  reset        in   1      synchronous active-high reset
//  start        in   1      begin execution; sampled in IDLE only
//  icode        in   4      instruction code from fetch; valid in FETCH cycle
//  imem_error   in   1      fetch address fault; valid in FETCH cycle
//  dmem_ack     in   1      data memory completion
//  dmem_error   in   1      data memory fault; qualified by dmem_ack
//  f_en/d_en/e_en/m_en/w_en/pc_en  out 1 each  one-hot stage strobes
//  cc_en        out  1      CC register write enable (OPq in EXECUTE)
//  dmem_req     out  1      data memory request, held until dmem_ack
//  stat         out  3      1=AOK 2=HLT 3=ADR 4=INS
//  busy         out  1      high in any state except IDLE/HALT
//  instr_count  out  CNT_W  retired instructions
// BEHAVIOUR
//  - Reset: state=IDLE, all strobes/cc_en/dmem_req/busy=0, stat=1, instr_count=0. Reset
//    mid-instruction aborts it; no strobe issued in the reset cycle or the one after.
//  - States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, MEM_WAIT, WRITEBACK, PCUPD, HALT.
//  - IDLE: start=1 -> FETCH. FETCH: f_en=1; icode latched to icode_q at cycle end.
//    Priority at end of FETCH: imem_error -> HALT stat=3; icode>4'hB -> HALT stat=4;
//    icode==0 -> HALT stat=2; else DECODE.
//  - DECODE -> EXECUTE -> MEMORY, one cycle each. cc_en=1 in EXECUTE iff icode_q==6, else 0.
//  - MEMORY: m_en=1. If icode_q in {4,5,8,9,A,B}: dmem_req=1; ack same cycle -> WRITEBACK,
//    else MEM_WAIT. Other icodes: no req, -> WRITEBACK.
//  - MEM_WAIT: dmem_req=1, m_en=0, wait counter +1/cycle; ack -> WRITEBACK; counter reaching
//    MEM_TIMEOUT without ack -> HALT stat=3. Counter cleared on entering MEMORY.
//  - dmem_ack with dmem_error=1 (MEMORY or MEM_WAIT) -> HALT stat=3; no writeback, no PC update.
//  - WRITEBACK: w_en=1 -> PCUPD. PCUPD: pc_en=1, instr_count+1 (wraps 2^CNT_W-1 -> 0) -> FETCH.
//  - Latency: non-memory instr 6 cycles; memory instr 6 + wait cycles.
//  - HALT: sticky; all strobes 0, busy=0, stat holds fault code; start ignored; exit by reset only.
//  - Exactly one of f_en..pc_en high in FETCH..PCUPD except MEM_WAIT (all low). Outputs registered
//    from state (Moore); dmem_req drops the cycle after ack.
//  - A halt instruction is not counted as retired.
// CONFIGURATION
//  SEQ_SINGLE_STEP_EN defined: extra input step (1b); PCUPD -> PAUSE state (busy=0, no strobes)
//    instead of FETCH; step=1 in PAUSE -> FETCH. start is ignored in PAUSE.
//  Undefined: no step port, no PAUSE state, PCUPD -> FETCH directly.
// TESTING
//  1. reset, start=1, icode=6 -> f,d,e,m,w,pc strobes on 6 consecutive cycles; cc_en only in
//     EXECUTE; instr_count=1; stat=1.
//  2. icode=4, dmem_ack after 3 wait cycles -> dmem_req high 4 cycles; total latency 9; count+1.
//  3. icode=5, no ack -> after 15 MEM_WAIT cycles, HALT, stat=3, busy=0, no w_en/pc_en.
//  4. icode=0 -> HALT stat=2 after FETCH; icode=C -> stat=4; imem_error=1 with icode=0 -> stat=3.
//  5. reset asserted during EXECUTE of icode=A -> next cycle IDLE, all outputs 0, count=0.
//  6. CNT_W=4, run 16 icode=1 instrs -> instr_count wraps 15 -> 0; with SEQ_SINGLE_STEP_EN,
//     each instr waits in PAUSE until step pulse.

Source files
------------

// File: rtl/seq_stage_ctrl.sv
// Y86-64 SEQ sequencer: one stage strobe per cycle, CC gating, dmem handshake, status.
// Optional SEQ_SINGLE_STEP_EN adds a step input and a PAUSE state after PC update.
module seq_stage_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             imem_error,
    input  logic             dmem_ack,
    input  logic             dmem_error,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic             f_en,
    output logic             d_en,
    output logic             e_en,
    output logic             m_en,
    output logic             w_en,
    output logic             pc_en,
    output logic             cc_en,
    output logic             dmem_req,
    output logic [2:0]       stat,
    output logic             busy,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [2:0] StatAok = 3'd1;
    localparam logic [2:0] StatHlt = 3'd2;
    localparam logic [2:0] StatAdr = 3'd3;
    localparam logic [2:0] StatIns = 3'd4;
    localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        MEMORY,
        MEM_WAIT,
        WRITEBACK,
        PCUPD,
        HALT
`ifdef SEQ_SINGLE_STEP_EN
        , PAUSE
`endif
    } state_t;

    state_t     state;
    state_t     nextState;
    logic [2:0] nextStat;
    logic [3:0] icodeQ;
    logic [7:0] waitCnt;
    logic       isMem;

    assign isMem = icodeQ inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};

    always_comb begin
        nextState = state;
        nextStat  = stat;
        unique case (state)
            IDLE: begin
                if (start) nextState = FETCH;
            end
            FETCH: begin
                if (imem_error) begin
                    nextState = HALT;
                    nextStat  = StatAdr;
                end else if (icode > 4'hB) begin
                    nextState = HALT;
                    nextStat  = StatIns;
                end else if (icode == 4'h0) begin
                    nextState = HALT;
                    nextStat  = StatHlt;
                end else begin
                    nextState = DECODE;
                end
            end
            DECODE:  nextState = EXECUTE;
            EXECUTE: nextState = MEMORY;
            MEMORY: begin
                if (!isMem) begin
                    nextState = WRITEBACK;
                end else if (dmem_ack) begin
                    nextState = dmem_error ? HALT : WRITEBACK;
                    if (dmem_error) nextStat = StatAdr;
                end else begin
                    nextState = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                // a late ack in the final wait cycle still completes normally
                if (dmem_ack) begin
                    nextState = dmem_error ? HALT : WRITEBACK;
                    if (dmem_error) nextStat = StatAdr;
                end else if (waitCnt == WaitLast) begin
                    nextState = HALT;
                    nextStat  = StatAdr;
                end
            end
            WRITEBACK: nextState = PCUPD;
`ifdef SEQ_SINGLE_STEP_EN
            PCUPD: nextState = PAUSE;
            PAUSE: begin
                if (step) nextState = FETCH;
            end
`else
            PCUPD: nextState = FETCH;
`endif
            HALT:    nextState = HALT;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            stat        <= StatAok;
            icodeQ      <= 4'h0;
            waitCnt     <= 8'd0;
            instr_count <= '0;
        end else begin
            state <= nextState;
            stat  <= nextStat;
            if (state == FETCH) icodeQ <= icode;
            if (state == MEMORY) waitCnt <= 8'd0;
            else if (state == MEM_WAIT) waitCnt <= waitCnt + 8'd1;
            if (state == PCUPD) instr_count <= instr_count + CNT_W'(1);
        end
    end

    assign f_en     = (state == FETCH);
    assign d_en     = (state == DECODE);
    assign e_en     = (state == EXECUTE);
    assign m_en     = (state == MEMORY);
    assign w_en     = (state == WRITEBACK);
    assign pc_en    = (state == PCUPD);
    assign cc_en    = (state == EXECUTE) && (icodeQ == 4'h6);
    assign dmem_req = ((state == MEMORY) && isMem) || (state == MEM_WAIT);
`ifdef SEQ_SINGLE_STEP_EN
    assign busy = !(state inside {IDLE, HALT, PAUSE});
`else
    assign busy = !(state inside {IDLE, HALT});
`endif

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Scoreboard bench for seq_stage_ctrl: per-cycle expected outputs queued, popped at negedge.
module tb_seq_stage_ctrl;

    localparam int CNT_W = 4;
    localparam int TO    = 15;

    logic             clk = 1'b0;
    logic             reset, start, imem_error, dmem_ack, dmem_error;
    logic [3:0]       icode;
    logic             f_en, d_en, e_en, m_en, w_en, pc_en, cc_en, dmem_req, busy;
    logic [2:0]       stat;
    logic [CNT_W-1:0] instr_count;
`ifdef SEQ_SINGLE_STEP_EN
    logic             step = 1'b0;
`endif

    seq_stage_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .icode(icode),
        .imem_error(imem_error), .dmem_ack(dmem_ack), .dmem_error(dmem_error),
`ifdef SEQ_SINGLE_STEP_EN
        .step(step),
`endif
        .f_en(f_en), .d_en(d_en), .e_en(e_en), .m_en(m_en), .w_en(w_en),
        .pc_en(pc_en), .cc_en(cc_en), .dmem_req(dmem_req), .stat(stat),
        .busy(busy), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0]      vec;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             sbq[$];
    int               vecCnt = 0;
    int               errCnt = 0;
    logic [CNT_W-1:0] expCnt = '0;
    string            phase = "reset";

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] want);
        vecCnt++;
        if (got !== want) begin
            errCnt++;
            $display("FAIL %s/%s got=%h want=%h t=%0t", phase, tag, got, want, $time);
        end
    endtask

    function automatic logic [11:0] mkVec(input int strobe, input logic cc,
                                          input logic req, input logic bsy,
                                          input logic [2:0] st);
        logic [5:0] s;
        s = 6'b0;
        if (strobe >= 0) s[5-strobe] = 1'b1;
        return {s, cc, req, bsy, st};
    endfunction

    task automatic push(input int strobe, input logic cc, input logic req,
                        input logic bsy, input logic [2:0] st);
        sbq.push_back('{vec: mkVec(strobe, cc, req, bsy, st), cnt: expCnt});
    endtask

    task automatic cyc(input logic [3:0] ic, input logic ie, input logic ack,
                       input logic err, input logic st);
        exp_t e;
        @(negedge clk);
        if (sbq.size() == 0) begin
            check("sbq_empty", 16'd0, 16'd1);
        end else begin
            e = sbq.pop_front();
            check("outs", 16'({f_en, d_en, e_en, m_en, w_en, pc_en,
                               cc_en, dmem_req, busy, stat}), 16'(e.vec));
            check("count", 16'(instr_count), 16'(e.cnt));
        end
        reset      = 1'b0;
        start      = st;
        icode      = ic;
        imem_error = ie;
        dmem_ack   = ack;
        dmem_error = err;
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b0;
`endif
    endtask

    task automatic rst();
        reset      = 1'b1;
        start      = 1'b0;
        icode      = 4'h0;
        imem_error = 1'b0;
        dmem_ack   = 1'b0;
        dmem_error = 1'b0;
        expCnt     = '0;
    endtask

    task automatic launch();
        push(-1, 0, 0, 0, 3'd1);
        cyc(4'h0, 0, 0, 0, 1);
    endtask

    task automatic haltChk(input logic [2:0] code);
        push(-1, 0, 0, 0, code);
        cyc(4'h0, 0, 0, 0, 1);
        push(-1, 0, 0, 0, code);
        cyc(4'h0, 0, 0, 0, 0);
    endtask

    // waitN: MEM_WAIT cycles before ack (0 = ack in MEMORY, >TO = never)
    task automatic runInstr(input logic [3:0] ic, input logic ie,
                            input int waitN, input logic ackErr);
        logic mem;
        mem = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
        push(0, 0, 0, 1, 3'd1);
        cyc(ic, ie, 0, 0, 0);
        if (ie) begin
            haltChk(3'd3);
            return;
        end
        if (ic > 4'hB) begin
            haltChk(3'd4);
            return;
        end
        if (ic == 4'h0) begin
            haltChk(3'd2);
            return;
        end
        push(1, 0, 0, 1, 3'd1);
        cyc(4'h0, 0, 0, 0, 0);
        push(2, ic == 4'h6, 0, 1, 3'd1);
        cyc(4'h0, 0, 0, 0, 0);
        if (!mem) begin
            push(3, 0, 0, 1, 3'd1);
            cyc(4'h0, 0, 1, 0, 0);
        end else begin
            push(3, 0, 1, 1, 3'd1);
            cyc(4'h0, 0, waitN == 0, (waitN == 0) && ackErr, 0);
            for (int k = 1; k <= waitN && k <= TO; k++) begin
                push(-1, 0, 1, 1, 3'd1);
                cyc(4'h0, 0, k == waitN, (k == waitN) && ackErr, 0);
            end
            if (waitN > TO || ackErr) begin
                haltChk(3'd3);
                return;
            end
        end
        push(4, 0, 0, 1, 3'd1);
        cyc(4'h0, 0, 0, 0, 0);
        push(5, 0, 0, 1, 3'd1);
        cyc(4'h0, 0, 0, 0, 0);
        expCnt = expCnt + CNT_W'(1);
`ifdef SEQ_SINGLE_STEP_EN
        push(-1, 0, 0, 0, 3'd1);
        cyc(4'h0, 0, 0, 0, 1);
        push(-1, 0, 0, 0, 3'd1);
        cyc(4'h0, 0, 0, 0, 0);
        step = 1'b1;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst();
        launch();
        phase = "opq";
        runInstr(4'h6, 0, 0, 0);
        phase = "rmmov_wait3";
        runInstr(4'h4, 0, 3, 0);
        phase = "call_ack0";
        runInstr(4'h8, 0, 0, 0);
        phase = "rrmov_stray_ack";
        runInstr(4'h2, 0, 0, 0);
        phase = "popq_wait14";
        runInstr(4'hB, 0, 14, 0);
        phase = "mrmov_timeout";
        runInstr(4'h5, 0, 99, 0);

        phase = "halt_instr";
        rst();
        launch();
        runInstr(4'h0, 0, 0, 0);
        phase = "bad_icode_c";
        rst();
        launch();
        runInstr(4'hC, 0, 0, 0);
        phase = "bad_icode_f";
        rst();
        launch();
        runInstr(4'hF, 0, 0, 0);
        phase = "imem_err";
        rst();
        launch();
        runInstr(4'h0, 1, 0, 0);
        phase = "dmem_err";
        rst();
        launch();
        runInstr(4'h1, 0, 0, 0);
        runInstr(4'h9, 0, 2, 1);

        phase = "reset_mid";
        rst();
        launch();
        runInstr(4'h3, 0, 0, 0);
        push(0, 0, 0, 1, 3'd1);
        cyc(4'hA, 0, 0, 0, 0);
        push(1, 0, 0, 1, 3'd1);
        cyc(4'h0, 0, 0, 0, 0);
        push(2, 0, 0, 1, 3'd1);
        cyc(4'h0, 0, 0, 0, 0);
        rst();
        launch();
        runInstr(4'h1, 0, 0, 0);

        phase = "wrap";
        rst();
        launch();
        for (int i = 0; i < 17; i++) runInstr(4'h1, 0, 0, 0);
        push(0, 0, 0, 1, 3'd1);
        cyc(4'h0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
